// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master driving two slaves selected by PADDR[SEL_BIT].
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_arb #(
  parameter int unsigned SEL_BIT        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        rsp_err,
  output logic [31:0] rdata,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic        PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state;
  logic        last_gnt;   // 1: requester 1 was granted most recently
  logic        served;     // requester owning the transfer in flight
  logic        gnt_id;
  logic        gnt_any;
  logic        gnt_wr;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic        to_hit;

  always_comb begin
    gnt_any   = req0 | req1;
    gnt_id    = (req0 && req1) ? ~last_gnt : req1;
    gnt_wr    = gnt_id ? wr1    : wr0;
    gnt_addr  = gnt_id ? addr1  : addr0;
    gnt_wdata = gnt_id ? wdata1 : wdata0;
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 2);

  logic [CW-1:0] acc_cnt;

  assign to_hit = (state == ACCESS) && (acc_cnt == CW'(TIMEOUT_CYCLES));

  // Loaded with 1 in SETUP so the first ACCESS cycle counts as cycle 1.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      acc_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= to_hit && !PREADY;
      if (state == SETUP)
        acc_cnt <= CW'(1);
      else if (state == ACCESS)
        acc_cnt <= acc_cnt + 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      served   <= 1'b0;
      PSEL1    <= 1'b0;
      PSEL2    <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      rdata    <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          // The cycle carrying done is a turnaround: requests are not sampled.
          if (!(done0 || done1) && gnt_any) begin
            state    <= SETUP;
            served   <= gnt_id;
            last_gnt <= gnt_id;
            PWRITE   <= gnt_wr;
            PADDR    <= gnt_addr;
            PWDATA   <= gnt_wdata;
            PSEL1    <= ~gnt_addr[SEL_BIT];
            PSEL2    <= gnt_addr[SEL_BIT];
            PENABLE  <= 1'b0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (PREADY || to_hit) begin
            state   <= IDLE;
            PSEL1   <= 1'b0;
            PSEL2   <= 1'b0;
            PENABLE <= 1'b0;
            done0   <= ~served;
            done1   <= served;
            if (PREADY && !PWRITE)
              rdata <= PSEL2 ? PRDATA2 : PRDATA1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed vector table, corner sequences,
// and randomized traffic checked against a transaction-level round-robin model.
module tb_apb_master_arb;

  localparam int unsigned SEL_BIT        = 8;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, rsp_err;
  logic [31:0] rdata;
  logic        PSEL1, PSEL2, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic        PREADY;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_rdata;
  int          last_gnt;

  logic        r_pend  [2];
  logic        r_wr    [2];
  logic [31:0] r_addr  [2];
  logic [31:0] r_wdata [2];

  apb_master_arb #(.SEL_BIT(SEL_BIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rsp_err(rsp_err), .rdata(rdata),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] p1;
    logic [31:0] p2;
    int unsigned waits;
    logic        e_psel1;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [5];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d; end
    else         begin req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) req0 = 1'b0;
    else         req1 = 1'b0;
  endtask

  task automatic new_req(input int id);
    r_pend[id]  = 1'b1;
    r_wr[id]    = 1'($urandom_range(0, 1));
    r_addr[id]  = $urandom;
    r_wdata[id] = $urandom;
    set_req(id, r_wr[id], r_addr[id], r_wdata[id]);
  endtask

  task automatic reset_dut();
    @(negedge PCLK);
    PRESET = 1'b1; req0 = 1'b0; req1 = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0; last_gnt = 1; exp_rdata = '0;
    r_pend[0] = 1'b0; r_pend[1] = 1'b0;
  endtask

  // Starts one negedge before the expected SETUP cycle; ends on the done cycle.
  task automatic xfer(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input int unsigned waits, input logic [31:0] p1, input logic [31:0] p2,
                      input logic e_psel1, input logic [31:0] e_rd);
    @(negedge PCLK);
    chk1("setup_psel1", PSEL1, e_psel1);
    chk1("setup_psel2", PSEL2, !e_psel1);
    chk1("setup_penable", PENABLE, 1'b0);
    chk1("setup_pwrite", PWRITE, wr);
    chk32("setup_paddr", PADDR, a);
    chk32("setup_pwdata", PWDATA, d);
    PRDATA1 = p1; PRDATA2 = p2;
    PREADY  = 1'($urandom_range(0, 1));
    for (int unsigned k = 0; k <= waits; k++) begin
      @(negedge PCLK);
      chk1("access_penable", PENABLE, 1'b1);
      chk1("access_psel1", PSEL1, e_psel1);
      chk1("access_psel2", PSEL2, !e_psel1);
      chk32("access_paddr", PADDR, a);
      chk1("access_no_done", done0 | done1, 1'b0);
      PREADY = (k == waits);
    end
    @(negedge PCLK);
    PREADY = 1'($urandom_range(0, 1));
    chk1("done0", done0, id == 0);
    chk1("done1", done1, id == 1);
    chk1("done_rsp_err", rsp_err, 1'b0);
    chk1("done_psel", PSEL1 | PSEL2, 1'b0);
    chk1("done_penable", PENABLE, 1'b0);
    chk32("done_rdata", rdata, e_rd);
    exp_rdata = e_rd;
    drop_req(id);
  endtask

  task automatic turnaround();
    @(negedge PCLK);
    chk1("turn_psel", PSEL1 | PSEL2, 1'b0);
    chk1("turn_done", done0 | done1, 1'b0);
    PREADY = 1'b0;
  endtask

  initial begin
    int          n;
    logic        seen;
    int          w;
    logic        e_psel1;
    logic [31:0] a_tmp, p1, p2, e_rd;

    PRESET = 1'b1; PREADY = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    PRDATA1 = '0; PRDATA2 = '0;
    last_gnt = 1; exp_rdata = '0;

    tbl[0] = '{0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0,         32'h0,         0, 1'b1, 32'h0};
    tbl[1] = '{1, 1'b0, 32'h0000_0104, 32'h0,         32'hAAAA_5555, 32'h1234_5678, 2, 1'b0, 32'h1234_5678};
    tbl[2] = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 32'h0,         1, 1'b1, 32'hCAFE_F00D};
    tbl[3] = '{1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1,         32'h2,         0, 1'b0, 32'hCAFE_F00D};
    tbl[4] = '{0, 1'b0, 32'hFFFF_FEFF, 32'h0,         32'h0BAD_C0DE, 32'h1111_1111, 3, 1'b1, 32'h0BAD_C0DE};

    @(negedge PCLK);
    chk1("rst_psel1", PSEL1, 1'b0);
    chk1("rst_psel2", PSEL2, 1'b0);
    chk1("rst_penable", PENABLE, 1'b0);
    chk1("rst_pwrite", PWRITE, 1'b0);
    chk1("rst_done", done0 | done1, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk32("rst_paddr", PADDR, 32'h0);
    chk32("rst_pwdata", PWDATA, 32'h0);
    chk32("rst_rdata", rdata, 32'h0);
    PRESET = 1'b0;

    foreach (tbl[i]) begin
      set_req(tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      xfer(tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits,
           tbl[i].p1, tbl[i].p2, tbl[i].e_psel1, tbl[i].e_rd);
      turnaround();
    end

    // Simultaneous requests after reset, re-asserted after each done: 0,1,0,1.
    reset_dut();
    set_req(0, 1'b1, 32'h0000_0020, 32'h1111_0000);
    set_req(1, 1'b0, 32'h0000_0120, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        xfer(0, 1'b1, 32'h0000_0020, 32'h1111_0000 + 32'(k), 0, 32'h0, 32'h0, 1'b1, exp_rdata);
        if (k < 2) set_req(0, 1'b1, 32'h0000_0020, 32'h1111_0000 + 32'(k + 2));
      end else begin
        xfer(1, 1'b0, 32'h0000_0120, 32'h0, 1, 32'h0, 32'hA0A0_0000 + 32'(k), 1'b0,
             32'hA0A0_0000 + 32'(k));
        if (k < 2) set_req(1, 1'b0, 32'h0000_0120, 32'h0);
      end
      turnaround();
    end

    // Slave never ready.
    reset_dut();
    set_req(0, 1'b0, 32'h0000_0008, 32'h0);
    @(negedge PCLK);
    chk1("to_setup", PSEL1 & !PENABLE, 1'b1);
    n = 0; seen = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge PCLK);
      if (done0 | done1) begin seen = 1'b1; break; end
      if (PENABLE) n++;
    end
`ifdef APB_TIMEOUT_EN
    chk32("to_access_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
    chk1("to_done0", done0, 1'b1);
    chk1("to_rsp_err", rsp_err, 1'b1);
    chk32("to_rdata", rdata, exp_rdata);
    chk1("to_penable", PENABLE, 1'b0);
`else
    chk1("noto_done", seen, 1'b0);
    chk32("noto_access_cycles", 32'(n), 32'd120);
    chk1("noto_rsp_err", rsp_err, 1'b0);
    chk1("noto_penable", PENABLE, 1'b1);
`endif

    // Reset in the second ACCESS cycle of a read aborts the transfer.
    reset_dut();
    set_req(0, 1'b0, 32'h0000_0030, 32'h0);
    xfer(0, 1'b0, 32'h0000_0030, 32'h0, 0, 32'h5A5A_5A5A, 32'h0, 1'b1, 32'h5A5A_5A5A);
    turnaround();
    set_req(0, 1'b0, 32'h0000_0004, 32'h0);
    @(negedge PCLK);
    chk1("abort_setup", PSEL1 & !PENABLE, 1'b1);
    PREADY = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk1("abort_access2", PENABLE, 1'b1);
    #1 PRESET = 1'b1;
    #1;
    chk1("abort_psel", PSEL1 | PSEL2, 1'b0);
    chk1("abort_penable", PENABLE, 1'b0);
    chk32("abort_rdata", rdata, 32'h0);
    @(negedge PCLK);
    chk1("abort_no_done", done0 | done1, 1'b0);
    PRESET = 1'b0; last_gnt = 1; exp_rdata = '0;
    xfer(0, 1'b0, 32'h0000_0004, 32'h0, 0, 32'h0000_0077, 32'h0, 1'b1, 32'h0000_0077);
    turnaround();

    // Randomized traffic against the round-robin transaction model.
    reset_dut();
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 2; i++)
        if (!r_pend[i] && $urandom_range(0, 1) == 1) new_req(i);
      if (!r_pend[0] && !r_pend[1]) new_req(int'($urandom_range(0, 1)));
      w        = (r_pend[0] && r_pend[1]) ? (last_gnt == 0 ? 1 : 0) : (r_pend[0] ? 0 : 1);
      last_gnt = w;
      a_tmp    = r_addr[w];
      e_psel1  = !a_tmp[SEL_BIT];
      p1       = $urandom;
      p2       = $urandom;
      e_rd     = r_wr[w] ? exp_rdata : (e_psel1 ? p1 : p2);
      xfer(w, r_wr[w], r_addr[w], r_wdata[w], $urandom_range(0, 3), p1, p2, e_psel1, e_rd);
      r_pend[w] = 1'b0;
      // Requests raised during the turnaround cycle must wait one more cycle.
      for (int i = 0; i < 2; i++)
        if (!r_pend[i] && $urandom_range(0, 2) == 0) new_req(i);
      turnaround();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter SEL_BIT, default 8: index of the PADDR bit that selects slave 1 (bit=0) or slave 2 (bit=1).
REQ-002 Parameter TIMEOUT_CYCLES, default 16: ACCESS-phase wait limit, used only when APB_TIMEOUT_EN is defined.
REQ-003 PCLK  in  1  sole clock; all state changes on the rising edge.
REQ-004 PRESET  in  1  asynchronous reset, active-high.
REQ-005 req0, req1  in  1  per-requester transfer request (level), held high until that requester's done.
REQ-006 wr0, wr1  in  1  per-requester direction: 1 write, 0 read.
REQ-007 addr0, addr1  in  32  per-requester transfer address.
REQ-008 wdata0, wdata1  in  32  per-requester write data.
REQ-009 done0, done1  out  1  one-cycle completion pulse to the served requester.
REQ-010 rsp_err  out  1  error flag, valid only while done0 or done1 is high.
REQ-011 rdata  out  32  read data of the last completed read, held until the next completed read.
REQ-012 PSEL1, PSEL2  out  1  APB slave selects.
REQ-013 PENABLE, PWRITE  out  1  APB phase and direction.
REQ-014 PADDR, PWDATA  out  32  APB address and write data.
REQ-015 PRDATA1, PRDATA2  in  32  read data from slave 1 and slave 2.
REQ-016 PREADY  in  1  slave ready, sampled only in ACCESS.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP and ACCESS; all APB outputs SHALL be registered.
REQ-018 In IDLE with done not asserted, any active req SHALL be granted: IDLE->SETUP; the granted wr, addr and wdata SHALL be latched into PWRITE, PADDR and PWDATA.
REQ-019 When both requests are active, grant SHALL be round-robin: the requester not granted last wins; after reset, req0 wins the first tie.
REQ-020 SETUP: exactly one cycle; PSEL1 = !PADDR[SEL_BIT], PSEL2 = PADDR[SEL_BIT], PENABLE = 0; SETUP->ACCESS unconditionally.
REQ-021 ACCESS: PENABLE = 1; PSEL, PADDR, PWRITE and PWDATA SHALL be held stable while PREADY = 0.
REQ-022 In ACCESS, PREADY = 1 at a clock edge SHALL complete the transfer: ACCESS->IDLE; PSEL and PENABLE drop; done of the served requester pulses for exactly one cycle; rsp_err = 0.
REQ-023 On read completion, rdata SHALL capture PRDATA1 or PRDATA2 per the selected slave at the completing edge; writes SHALL leave rdata unchanged.
REQ-024 The IDLE cycle in which done is high is a turnaround cycle: req SHALL NOT be sampled and no grant SHALL occur.
REQ-025 Minimum transfer: grant edge, SETUP, ACCESS, done cycle; each PREADY=0 cycle adds one ACCESS cycle.
REQ-026 PREADY in IDLE or SETUP SHALL be ignored; req changes after grant SHALL be ignored until the next IDLE.
REQ-027 At most one of PSEL1 and PSEL2 SHALL be high at any time; done0 and done1 SHALL never be high together.

Reset
REQ-028 PRESET high SHALL immediately force: state IDLE; PSEL1, PSEL2, PENABLE, PWRITE, done0, done1 and rsp_err to 0; PADDR, PWDATA and rdata to 0x00000000; round-robin pointer to favour req0.
REQ-029 Reset during SETUP or ACCESS SHALL abort the transfer with no done pulse; after release, a held req SHALL restart from grant.

Configuration
REQ-030 With macro APB_TIMEOUT_EN defined, an ACCESS-cycle counter SHALL count from 1. If PREADY is still 0 when the count reaches TIMEOUT_CYCLES: ACCESS->IDLE; done pulses with rsp_err = 1; rdata unchanged. The counter clears on each entry to SETUP.
REQ-031 Without APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely for PREADY, rsp_err SHALL be tied to 0, and no counter logic SHALL be present.

Verification
REQ-032 req0 write, addr0=0x00000004, wdata0=0xDEADBEEF, PREADY=1 -> PSEL1=1/PENABLE=0 for 1 cycle, then PENABLE=1 for 1 cycle, then done0 for 1 cycle; PSEL2 stays 0.
REQ-033 req1 read, addr1=0x00000104, PRDATA2=0x12345678, two wait states -> PSEL2 high, ACCESS lasts 3 cycles, done1 pulses, rdata=0x12345678.
REQ-034 req0 and req1 asserted together right after reset and re-asserted after each done -> grant order 0,1,0,1 with one turnaround cycle between transfers.
REQ-035 APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, PREADY held 0 -> done after 16 ACCESS cycles with rsp_err=1; without the macro, still in ACCESS after 100 cycles with rsp_err=0.
REQ-036 PRESET pulsed in the 2nd ACCESS cycle of a read -> PSEL and PENABLE drop without waiting for PCLK, no done, rdata=0; after release, the held req0 gets SETUP on the cycle after grant.
